// File: rtl/wb_regfile_pkg.sv
// Shared constants and encodings for the write-back / register-file slice.
// Consumers pull them in with import wb_regfile_pkg::*.
package wb_regfile_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int CPU_CNT_W  = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    MTR_ALU = 1'b0,
    MTR_MEM = 1'b1
  } mtr_e;

  function automatic logic is_commit(
    input logic                  we,
    input logic [CPU_ADDR_W-1:0] rd
  );
    return we && (rd != CPU_ADDR_W'(REG_ZERO));
  endfunction

endpackage

// File: rtl/wb_mux.sv
// 2:1 write-back data select, shared with the forwarding path.
// Selects load data or ALU result by the MemtoReg encoding.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int W = CPU_DATA_W
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_alu,
  input  logic [W-1:0] i_mem,
  output logic [W-1:0] o_data
);

  assign o_data = (mtr_e'(i_sel) == MTR_MEM) ? i_mem : i_alu;

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB write-back merged with the architectural register file.
// Two combinational read ports bypass the same-cycle write.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int CNT_W  = CPU_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] mux0_i,
  input  logic [DATA_W-1:0] mux1_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic [CNT_W-1:0]  WBcount_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_wb;
  logic              w_commit;
  logic              w_rs_zero;
  logic              w_rt_zero;
  logic              w_rs_byp;
  logic              w_rt_byp;

  wb_mux #(
    .W(DATA_W)
  ) u_wb_mux (
    .i_sel (MemtoReg_i),
    .i_alu (mux0_i),
    .i_mem (mux1_i),
    .o_data(w_wb)
  );

  assign w_commit = RegWrite_i
                 && (RDaddr_i != ADDR_W'(REG_ZERO));

  // Entry 0 is never written, so it stays at its reset value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_cnt <= '0;
    end else if (w_commit) begin
      r_mem[RDaddr_i] <= w_wb;
      r_cnt           <= r_cnt + 1'b1;
    end
  end

  assign w_rs_zero = (RSaddr_i == ADDR_W'(REG_ZERO));
  assign w_rt_zero = (RTaddr_i == ADDR_W'(REG_ZERO));
  assign w_rs_byp  = RegWrite_i && !w_rs_zero
                  && (RSaddr_i == RDaddr_i);
  assign w_rt_byp  = RegWrite_i && !w_rt_zero
                  && (RTaddr_i == RDaddr_i);

  always_comb begin
    unique case (1'b1)
      w_rs_zero: RSdata_o = '0;
      w_rs_byp:  RSdata_o = w_wb;
      default:   RSdata_o = r_mem[RSaddr_i];
    endcase
  end

  always_comb begin
    unique case (1'b1)
      w_rt_zero: RTdata_o = '0;
      w_rt_byp:  RTdata_o = w_wb;
      default:   RTdata_o = r_mem[RTaddr_i];
    endcase
  end

  assign WBdata_o  = w_wb;
  assign WBcount_o = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed cases plus random traffic
// against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        mtr = 1'b0;
  logic [31:0] m0 = '0;
  logic [31:0] m1 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;

  logic [31:0] rs_d, rt_d, wb_d, cnt_d;
  logic [31:0] rs_s, rt_s, wb_s;
  logic [3:0]  cnt_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [32];
  longint unsigned mcnt = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(we), .MemtoReg_i(mtr),
    .mux0_i(m0), .mux1_i(m1),
    .RDaddr_i(rd), .RSaddr_i(rs), .RTaddr_i(rt),
    .RSdata_o(rs_d), .RTdata_o(rt_d),
    .WBdata_o(wb_d), .WBcount_o(cnt_d)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(we), .MemtoReg_i(mtr),
    .mux0_i(m0), .mux1_i(m1),
    .RDaddr_i(rd), .RSaddr_i(rs), .RTaddr_i(rt),
    .RSdata_o(rs_s), .RTdata_o(rt_s),
    .WBdata_o(wb_s), .WBcount_o(cnt_s)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_val();
    return mtr ? m1 : m0;
  endfunction

  function automatic logic [31:0] rd_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && a == rd) return wb_val();
    return mdl[a];
  endfunction

  // Reference model: architectural state updated from the rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mcnt = 0;
    end else begin
      if (chk_en) chk("we_known", 64'($isunknown(we)), 64'd0);
      if (we === 1'b1 && rd != 5'd0) begin
        mdl[rd] = wb_val();
        mcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wbdata", 64'(wb_d), 64'(wb_val()));
      chk("rsdata", 64'(rs_d), 64'(rd_val(rs)));
      chk("rtdata", 64'(rt_d), 64'(rd_val(rt)));
      chk("count",  64'(cnt_d), 64'(mcnt[31:0]));
      chk("rs_w4",  64'(rs_s), 64'(rd_val(rs)));
      chk("rt_w4",  64'(rt_s), 64'(rd_val(rt)));
      chk("wb_w4",  64'(wb_s), 64'(wb_val()));
      chk("cnt_w4", 64'(cnt_s), 64'(mcnt[3:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic s,
                       input logic [31:0] a0,
                       input logic [31:0] a1,
                       input logic [4:0] d,
                       input logic [4:0] ra,
                       input logic [4:0] rb);
    we = w; mtr = s; m0 = a0; m1 = a1;
    rd = d; rs = ra; rt = rb;
  endtask

  initial begin
    // 1: reset, then sweep every address
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 5'(a), 5'(31 - a));
      @(negedge clk);
      chk("rst_rs", 64'(rs_d), 64'd0);
      chk("rst_rt", 64'(rt_d), 64'd0);
      step();
    end
    chk("rst_cnt", 64'(cnt_d), 64'd0);

    // 2: ALU result commit to r5
    drive(1'b1, 1'b0, 32'h1234, 32'h9999, 5'd5, 5'd1, 5'd2);
    step();
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd5, 5'd0);
    @(negedge clk);
    chk("r5", 64'(rs_d), 64'h1234);
    chk("cnt1", 64'(cnt_d), 64'd1);
    step();

    // 3: load data to r7, read on both ports
    drive(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 5'd7, 5'd7, 5'd7);
    @(negedge clk);
    chk("byp_rs", 64'(rs_d), 64'hDEADBEEF);
    chk("byp_rt", 64'(rt_d), 64'hDEADBEEF);
    step();
    drive(1'b0, 1'b0, 32'h11, 32'h22, 5'd7, 5'd7, 5'd7);
    @(negedge clk);
    chk("st_rs", 64'(rs_d), 64'hDEADBEEF);
    chk("st_rt", 64'(rt_d), 64'hDEADBEEF);
    chk("cnt2", 64'(cnt_d), 64'd2);
    step();

    // 4: write to r0 is dropped
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("r0_nobyp", 64'(rs_d), 64'd0);
    chk("r0_wb", 64'(wb_d), 64'hFFFFFFFF);
    step();
    drive(1'b0, 1'b0, '0, '0, '0, 5'd0, 5'd7);
    @(negedge clk);
    chk("r0_read", 64'(rs_d), 64'd0);
    chk("r0_cnt", 64'(cnt_d), 64'd2);
    step();

    // 6: reset mid-cycle with a write pending
    drive(1'b1, 1'b0, 32'hA5, 32'h0, 5'd3, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b0, 32'h5A, 32'h0, 5'd3, 5'd3, 5'd3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_cnt_now", 64'(cnt_d), 64'd0);
    we = 1'b0;
    #1;
    chk("rst_r3_now", 64'(rs_d), 64'd0);
    we = 1'b1;
    step();
    rst_n = 1'b1;
    we = 1'b0;
    @(negedge clk);
    chk("rst_r3_after", 64'(rt_d), 64'd0);
    chk("rst_cnt_after", 64'(cnt_d), 64'd0);
    step();

    // 5: 17 commits wrap the 4-bit counter to 1
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b0, 32'(k * 3 + 1), 32'h0,
            5'(1 + k % 31), 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 5'd17, 5'd1);
    @(negedge clk);
    chk("wrap4", 64'(cnt_s), 64'd1);
    chk("cnt17", 64'(cnt_d), 64'd17);
    chk("r17", 64'(rs_d), 64'd49);
    step();

    // random traffic; narrow rd range stresses bypass
    for (int k = 0; k < 600; k++) begin
      we  = ($urandom_range(0, 3) != 0);
      mtr = 1'($urandom_range(0, 1));
      m0  = $urandom;
      m1  = $urandom;
      rd  = ($urandom_range(0, 1) != 0) ?
            5'($urandom_range(0, 7)) :
            5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 2) == 0) ? rd :
            5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 2) == 0) ? rd :
            5'($urandom_range(0, 31));
      step();
    end

    we = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
